// File: rtl/display_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_port_arbiter: frame-memory port-B share, video vs. CPU bytes     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module display_port_arbiter #(
    parameter int RD_LAT  = 2,
    parameter int HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        visible,
    input  logic [18:0] vid_addr,
    output logic [7:0]  vid_data,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_write,
    input  logic [18:0] cpu_req_addr,
    input  logic [7:0]  cpu_req_wdata,
    output logic        cpu_rsp_valid,
    output logic [7:0]  cpu_rsp_data,
    output logic [18:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_wren,
    input  logic [7:0]  mem_q,
    output logic        cpu_window
);

    localparam logic [1:0] c_st_video   = 2'd0;
    localparam logic [1:0] c_st_holdoff = 2'd1;
    localparam logic [1:0] c_st_window  = 2'd2;

    localparam logic [1:0] c_tag_none = 2'd0;
    localparam logic [1:0] c_tag_vid  = 2'd1;
    localparam logic [1:0] c_tag_cpu  = 2'd2;

    localparam logic       c_direct     = (HOLDOFF <= 1);
    localparam logic       c_no_holdoff = (HOLDOFF == 0);
    localparam logic [7:0] c_last       = (HOLDOFF > 1) ? 8'(HOLDOFF - 1) : 8'd0;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [7:0]  w_cnt_inc;

    logic        r_hold_valid;
    logic        r_hold_write;
    logic [18:0] r_hold_addr;
    logic [7:0]  r_hold_wdata;

    logic        w_cpu_issue;
    logic [1:0]  w_tag_in;
    logic [1:0]  r_tag [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_holdoff;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cnt_inc    = r_cnt + 8'd1;
        case (r_state)
            c_st_video: begin
                if (!visible) begin
                    if (c_direct) begin
                        w_state_next = c_st_window;
                    end else begin
                        w_state_next = c_st_holdoff;
                        w_cnt_next   = 8'd0;
                    end
                end
            end
            c_st_holdoff: begin
                if (visible) begin
                    w_state_next = c_st_video;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (c_direct || (w_cnt_inc >= c_last)) begin
                        w_state_next = c_st_window;
                    end
                end
            end
            c_st_window: begin
                if (visible) begin
                    w_state_next = c_st_video;
                end
            end
            default: begin
                w_state_next = c_st_holdoff;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // With no hold-off the very first blank cycle may carry a processor access,
    // even though the state register has not yet reached WINDOW.
    always_comb begin
        cpu_window  = (r_state == c_st_window);
        w_cpu_issue = !visible && r_hold_valid && (cpu_window || c_no_holdoff);
        mem_address = 19'd0;
        mem_data    = 8'd0;
        mem_wren    = 1'b0;
        w_tag_in    = c_tag_none;
        if (visible) begin
            mem_address = vid_addr;
            w_tag_in    = c_tag_vid;
        end else if (w_cpu_issue) begin
            mem_address = r_hold_addr;
            mem_data    = r_hold_wdata;
            mem_wren    = r_hold_write;
            w_tag_in    = r_hold_write ? c_tag_none : c_tag_cpu;
        end
    end

    assign cpu_req_ready = !r_hold_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_write <= 1'b0;
            r_hold_addr  <= 19'd0;
            r_hold_wdata <= 8'd0;
        end else if (w_cpu_issue) begin
            r_hold_valid <= 1'b0;
        end else if (cpu_req_valid && !r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_write <= cpu_req_write;
            r_hold_addr  <= cpu_req_addr;
            r_hold_wdata <= cpu_req_wdata;
        end
    end

    // The oldest tag lines up with the RAM data for the access that pushed it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= c_tag_none;
            end
            vid_data      <= 8'd0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_data  <= 8'd0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            vid_data      <= (r_tag[RD_LAT-1] == c_tag_vid) ? mem_q : 8'd0;
            cpu_rsp_valid <= (r_tag[RD_LAT-1] == c_tag_cpu);
            if (r_tag[RD_LAT-1] == c_tag_cpu) begin
                cpu_rsp_data <= mem_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_port_arbiter: directed vectors plus a cycle-level model       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_display_port_arbiter;

    localparam int RD_LAT  = 2;
    localparam int HOLDOFF = 4;
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_VID  = 2'd1;
    localparam logic [1:0] K_CPU  = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, visible, cpu_req_valid, cpu_req_ready, cpu_req_write;
    logic        cpu_rsp_valid, mem_wren, cpu_window;
    logic [18:0] vid_addr, cpu_req_addr, mem_address;
    logic [7:0]  vid_data, cpu_req_wdata, cpu_rsp_data, mem_data, mem_q;

    logic        z_reset, z_visible, z_valid, z_ready, z_write, z_rsp_valid, z_wren, z_window;
    logic [18:0] z_vid_addr, z_addr, z_mem_address;
    logic [7:0]  z_vid_data, z_wdata, z_rsp_data, z_mem_data, z_mem_q;

    int vectors = 0;
    int miscompares = 0;
    int pulses;
    int got;
    logic [7:0] rsp_cap;

    display_port_arbiter #(.RD_LAT(RD_LAT), .HOLDOFF(HOLDOFF)) u_dut (
        .clk(clk), .reset(reset), .visible(visible), .vid_addr(vid_addr), .vid_data(vid_data),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_data(cpu_rsp_data), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q), .cpu_window(cpu_window)
    );

    display_port_arbiter #(.RD_LAT(RD_LAT), .HOLDOFF(0)) u_dut_z (
        .clk(clk), .reset(z_reset), .visible(z_visible), .vid_addr(z_vid_addr), .vid_data(z_vid_data),
        .cpu_req_valid(z_valid), .cpu_req_ready(z_ready), .cpu_req_write(z_write),
        .cpu_req_addr(z_addr), .cpu_req_wdata(z_wdata), .cpu_rsp_valid(z_rsp_valid),
        .cpu_rsp_data(z_rsp_data), .mem_address(z_mem_address), .mem_data(z_mem_data),
        .mem_wren(z_wren), .mem_q(z_mem_q), .cpu_window(z_window)
    );

    function automatic logic [7:0] init_val(input int a);
        return 8'(a + 16);
    endfunction

    // Frame memory: synchronous, RD_LAT cycles from address to data.
    logic [7:0] ram [0:1023];
    logic [7:0] rd_pipe [RD_LAT];
    logic [7:0] z_pipe [RD_LAT];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
        for (int i = 0; i < RD_LAT; i++) begin
            rd_pipe[i] <= 8'd0;
            z_pipe[i]  <= 8'd0;
        end
    end

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address[9:0]] <= mem_data;
        rd_pipe[0] <= ram[mem_address[9:0]];
        z_pipe[0]  <= ram[z_mem_address[9:0]];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            z_pipe[i]  <= z_pipe[i-1];
        end
    end
    assign mem_q   = rd_pipe[RD_LAT-1];
    assign z_mem_q = z_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Counts response pulses over one cycle while advancing to the next.
    task automatic watch_cycle;
        @(negedge clk);
        if (cpu_rsp_valid) begin
            pulses++;
            rsp_cap = cpu_rsp_data;
        end
        next_cycle();
    endtask

    // Model: processor access allowed once HOLDOFF blank cycles have passed;
    // each cycle's access is remembered and surfaces RD_LAT+1 cycles later.
    initial begin : model
        logic [1:0]  h_kind [0:RD_LAT];
        logic [7:0]  h_data [0:RD_LAT];
        logic [7:0]  exp_mem [0:1023];
        int          quiet;
        logic        m_hv, m_hw, win, e_issue, e_rv, e_wren;
        logic [18:0] m_ha, e_addr;
        logic [7:0]  m_hd, m_rsp, e_data, e_vid;
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
        for (int i = 0; i <= RD_LAT; i++) begin
            h_kind[i] = K_NONE;
            h_data[i] = 8'd0;
        end
        quiet = 1; m_hv = 1'b0; m_hw = 1'b0; m_ha = 19'd0; m_hd = 8'd0; m_rsp = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_vid_data", vid_data, 0);
                chk("rst_rsp_valid", cpu_rsp_valid, 0);
                chk("rst_rsp_data", cpu_rsp_data, 0);
                chk("rst_ready", cpu_req_ready, 1);
                chk("rst_window", cpu_window, 0);
                chk("rst_mem_address", mem_address, visible ? vid_addr : 19'd0);
                chk("rst_mem_wren", mem_wren, 0);
                for (int i = 0; i <= RD_LAT; i++) h_kind[i] = K_NONE;
                quiet = 1; m_hv = 1'b0; m_rsp = 8'd0;
            end else begin
                win     = (quiet >= HOLDOFF);
                e_issue = !visible && win && m_hv;
                e_addr  = visible ? vid_addr : (e_issue ? m_ha : 19'd0);
                e_wren  = e_issue && m_hw;
                e_data  = e_issue ? m_hd : 8'd0;
                e_vid   = (h_kind[RD_LAT] == K_VID) ? h_data[RD_LAT] : 8'd0;
                e_rv    = (h_kind[RD_LAT] == K_CPU);
                if (e_rv) m_rsp = h_data[RD_LAT];
                chk("mem_address", mem_address, e_addr);
                chk("mem_wren", mem_wren, e_wren);
                chk("mem_data", mem_data, e_data);
                chk("cpu_req_ready", cpu_req_ready, !m_hv);
                chk("cpu_window", cpu_window, win);
                chk("vid_data", vid_data, e_vid);
                chk("cpu_rsp_valid", cpu_rsp_valid, e_rv);
                chk("cpu_rsp_data", cpu_rsp_data, m_rsp);
                for (int i = RD_LAT; i > 0; i--) begin
                    h_kind[i] = h_kind[i-1];
                    h_data[i] = h_data[i-1];
                end
                h_kind[0] = visible ? K_VID : ((e_issue && !m_hw) ? K_CPU : K_NONE);
                h_data[0] = visible ? exp_mem[vid_addr[9:0]] : exp_mem[m_ha[9:0]];
                if (e_wren) exp_mem[m_ha[9:0]] = m_hd;
                if (e_issue) begin
                    m_hv = 1'b0;
                end else if (cpu_req_valid && !m_hv) begin
                    m_hv = 1'b1; m_hw = cpu_req_write; m_ha = cpu_req_addr; m_hd = cpu_req_wdata;
                end
                quiet = visible ? 0 : ((quiet < 1000) ? quiet + 1 : quiet);
            end
        end
    end

    initial begin
        reset = 1'b1; visible = 1'b0; vid_addr = 19'd0;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = 19'd0; cpu_req_wdata = 8'd0;
        z_reset = 1'b1; z_visible = 1'b0; z_vid_addr = 19'd0;
        z_valid = 1'b0; z_write = 1'b0; z_addr = 19'd0; z_wdata = 8'd0;
        pulses = 0; got = 0; rsp_cap = 8'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cpu_req_ready, 1);
        chk("window_after_reset", cpu_window, 0);
        next_cycle();

        // Video stream 0..10 with a write queued during the visible period
        for (int k = 0; k < 11; k++) begin
            visible = 1'b1; vid_addr = 19'(k);
            cpu_req_valid = (k == 0); cpu_req_write = 1'b1;
            cpu_req_addr = 19'h00100; cpu_req_wdata = 8'hA5;
            @(negedge clk);
            if (k >= 3) chk("vid_seq", vid_data, 32'(k - 3 + 16));
            if (k == 10) chk("write_held", cpu_req_ready, 0);
            next_cycle();
        end

        // Blanking: the held write must appear exactly four cycles after the fall
        visible = 1'b0; cpu_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("wr_wren", mem_wren, 1);
                chk("wr_addr", mem_address, 19'h00100);
                chk("wr_data", mem_data, 8'hA5);
            end else begin
                chk("wr_early", mem_wren, 0);
            end
            next_cycle();
        end

        // Read-after-write
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 19'h00100;
        next_cycle();
        cpu_req_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            @(negedge clk);
            if (cpu_rsp_valid) begin
                got = 1;
                chk("raw_data", cpu_rsp_data, 8'hA5);
                chk("raw_latency", k, 3);
            end
            next_cycle();
        end
        chk("raw_rsp_seen", got, 1);

        // Read deferred by video returning in the first window cycle
        pulses = 0;
        visible = 1'b1; vid_addr = 19'd1;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 19'h00005;
        watch_cycle();
        cpu_req_valid = 1'b0; vid_addr = 19'd2;
        watch_cycle();
        visible = 1'b0;
        repeat (4) watch_cycle();
        visible = 1'b1; vid_addr = 19'd3;
        @(negedge clk);
        chk("defer_addr", mem_address, 19'd3);
        chk("defer_ready", cpu_req_ready, 0);
        chk("defer_window", cpu_window, 1);
        if (cpu_rsp_valid) pulses++;
        next_cycle();
        vid_addr = 19'd4;
        watch_cycle();
        visible = 1'b0;
        repeat (10) watch_cycle();
        chk("defer_pulses", pulses, 1);
        chk("defer_data", rsp_cap, 8'h15);

        // Reset mid-frame with a write held
        for (int k = 10; k < 14; k++) begin
            visible = 1'b1; vid_addr = 19'(k);
            cpu_req_valid = (k == 10); cpu_req_write = 1'b1;
            cpu_req_addr = 19'h00020; cpu_req_wdata = 8'h3C;
            next_cycle();
        end
        cpu_req_valid = 1'b0; vid_addr = 19'd14;
        reset = 1'b1;
        #1;
        chk("async_vid_data", vid_data, 0);
        chk("async_rsp_data", cpu_rsp_data, 0);
        chk("async_ready", cpu_req_ready, 1);
        chk("async_window", cpu_window, 0);
        chk("async_mem_address", mem_address, 19'd14);
        next_cycle();
        reset = 1'b0; visible = 1'b0;
        repeat (6) next_cycle();

        // Reset one cycle after a read issues: the response must vanish
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 19'h00007;
        next_cycle();
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("r6_issue_addr", mem_address, 19'h00007);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        pulses = 0;
        repeat (8) watch_cycle();
        chk("r6_pulses", pulses, 0);
        chk("r6_ready", cpu_req_ready, 1);

        // Zero hold-off instance
        z_reset = 1'b0; z_visible = 1'b1; z_vid_addr = 19'd0;
        z_valid = 1'b1; z_write = 1'b0; z_addr = 19'h00009;
        @(negedge clk);
        chk("z_ready", z_ready, 1);
        next_cycle();
        z_valid = 1'b0;
        repeat (2) next_cycle();
        z_visible = 1'b0;
        @(negedge clk);
        chk("z_issue_addr", z_mem_address, 19'h00009);
        chk("z_issue_wren", z_wren, 0);
        chk("z_issue_window", z_window, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("z_last_pixel", z_vid_data, 8'd16);
        next_cycle();
        @(negedge clk);
        chk("z_rsp_valid", z_rsp_valid, 1);
        chk("z_rsp_data", z_rsp_data, 8'd25);
        chk("z_black_rsp", z_vid_data, 0);
        next_cycle();
        @(negedge clk);
        chk("z_black_after", z_vid_data, 0);
        chk("z_rsp_pulse_end", z_rsp_valid, 0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
